// File: rtl/request_scheduler.sv
// request_scheduler: latches the ten elevator call buttons and issues the next target code
// to the floor FSM in SCAN (keep-direction) order, holding the target while the doors are open.
module request_scheduler #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] btn_cab,
  input  logic [2:0] btn_up,
  input  logic [2:0] btn_down,
  input  logic [1:0] piso,
  input  logic       puertas,
  output logic [3:0] memoria,
  output logic [9:0] pending,
  output logic [1:0] dir
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_UP    = 2'd1;
  localparam logic [1:0] ST_DOWN  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;
  localparam logic [1:0] DIR_IDLE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;
  localparam int CW = $clog2(DOOR_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    pend_q, pend_d;
  logic [3:0]    mem_q, mem_d;
  logic [1:0]    dir_q, dir_d;

  logic [9:0] btn_vec;
  logic       hold_exit;
  logic [3:0] req, ge_mask, le_mask, up_req, dn_req;
  logic [1:0] up_t, dn_t, up_dist, dn_dist, sel_t, sel_dir;
  logic       up_ok, dn_ok, sel_any, has_up, has_dn;
  logic [3:0] up_code, dn_code, sel_mem;

  // Cabin bit plus the hall bits of one floor.
  function automatic logic [9:0] floor_mask(input logic [1:0] f);
    logic [9:0] m;
    case (f)
      2'd0:    m = 10'b00_0001_0001;
      2'd1:    m = 10'b00_0110_0010;
      2'd2:    m = 10'b01_1000_0100;
      default: m = 10'b10_0000_1000;
    endcase
    return m;
  endfunction

  always_comb begin
    btn_vec   = {btn_down[2], btn_up[2], btn_down[1], btn_up[1], btn_down[0], btn_up[0], btn_cab};
    hold_exit = en && (state_q == ST_HOLD) && (cnt_q == CW'(DOOR_CYCLES - 1));
    // The served floor's clear beats any simultaneous press for that floor.
    pend_d    = (pend_q | btn_vec) & ~(hold_exit ? floor_mask(piso) : 10'd0);
    req       = {pend_d[3] | pend_d[9],
                 pend_d[2] | pend_d[7] | pend_d[8],
                 pend_d[1] | pend_d[5] | pend_d[6],
                 pend_d[0] | pend_d[4]};
  end

  always_comb begin
    case (piso)
      2'd0:    begin ge_mask = 4'b1111; le_mask = 4'b0001; end
      2'd1:    begin ge_mask = 4'b1110; le_mask = 4'b0011; end
      2'd2:    begin ge_mask = 4'b1100; le_mask = 4'b0111; end
      default: begin ge_mask = 4'b1000; le_mask = 4'b1111; end
    endcase
    up_req = req & ge_mask;
    dn_req = req & le_mask;
    up_ok  = |up_req;
    dn_ok  = |dn_req;
    if (up_req[0])      up_t = 2'd0;
    else if (up_req[1]) up_t = 2'd1;
    else if (up_req[2]) up_t = 2'd2;
    else                up_t = 2'd3;
    if (dn_req[3])      dn_t = 2'd3;
    else if (dn_req[2]) dn_t = 2'd2;
    else if (dn_req[1]) dn_t = 2'd1;
    else                dn_t = 2'd0;
    up_dist = up_t - piso;
    dn_dist = piso - dn_t;
  end

  always_comb begin
    sel_t   = up_t;
    sel_dir = DIR_IDLE;
    sel_any = up_ok | dn_ok;
    case (dir_q)
      DIR_UP: begin
        if (up_ok)      begin sel_t = up_t; sel_dir = DIR_UP;   end
        else if (dn_ok) begin sel_t = dn_t; sel_dir = DIR_DOWN; end
      end
      DIR_DOWN: begin
        if (dn_ok)      begin sel_t = dn_t; sel_dir = DIR_DOWN; end
        else if (up_ok) begin sel_t = up_t; sel_dir = DIR_UP;   end
      end
      default: begin
        // Equal distance resolves to the higher floor.
        if (up_ok && (!dn_ok || up_dist <= dn_dist)) sel_t = up_t;
        else                                          sel_t = dn_t;
        if (!sel_any)          sel_dir = DIR_IDLE;
        else if (sel_t > piso) sel_dir = DIR_UP;
        else if (sel_t < piso) sel_dir = DIR_DOWN;
        else                   sel_dir = DIR_IDLE;
      end
    endcase
  end

  always_comb begin
    case (sel_t)
      2'd0:    begin has_up = pend_d[4]; up_code = 4'd5; has_dn = 1'b0;      dn_code = 4'd0;  end
      2'd1:    begin has_up = pend_d[6]; up_code = 4'd7; has_dn = pend_d[5]; dn_code = 4'd6;  end
      2'd2:    begin has_up = pend_d[8]; up_code = 4'd9; has_dn = pend_d[7]; dn_code = 4'd8;  end
      default: begin has_up = 1'b0;      up_code = 4'd0; has_dn = pend_d[9]; dn_code = 4'd10; end
    endcase
    if (!sel_any)               sel_mem = 4'd0;
    else if (pend_d[sel_t])     sel_mem = {2'b00, sel_t} + 4'd1;
    else if (sel_dir == DIR_DOWN) sel_mem = has_dn ? dn_code : up_code;
    else                        sel_mem = has_up ? up_code : dn_code;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    dir_d   = dir_q;
    if (en) begin
      if (state_q == ST_HOLD) begin
        if (hold_exit) begin
          state_d = sel_dir;
          dir_d   = sel_dir;
          mem_d   = sel_mem;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (puertas) begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end else begin
        state_d = sel_dir;
        dir_d   = sel_dir;
        mem_d   = sel_mem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      mem_q   <= '0;
      dir_q   <= DIR_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mem_q   <= mem_d;
      dir_q   <= dir_d;
    end
  end

  assign memoria = mem_q;
  assign pending = pend_q;
  assign dir     = dir_q;

endmodule

// File: tb/tb_request_scheduler.sv
// tb_request_scheduler: directed and random stimulus against a code-map reference model,
// with a queue-based scoreboard checked one edge after each drive.
module tb_request_scheduler;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] btn_cab = '0;
  logic [2:0] btn_up = '0;
  logic [2:0] btn_down = '0;
  logic [1:0] piso = '0;
  logic       puertas = 1'b0;
  logic [3:0] memoria;
  logic [9:0] pending;
  logic [1:0] dir;

  request_scheduler #(.DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .en(en), .btn_cab(btn_cab), .btn_up(btn_up),
    .btn_down(btn_down), .piso(piso), .puertas(puertas),
    .memoria(memoria), .pending(pending), .dir(dir)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mem;
    logic [9:0] pend;
    logic [1:0] dir;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  // Reference model: calls kept per code, floors numbered 1..4.
  int code_floor[1:10] = '{1, 2, 3, 4, 1, 2, 2, 3, 3, 4};
  int code_kind[1:10]  = '{0, 0, 0, 0, 1, 2, 1, 2, 1, 2};  // 0 cabin, 1 up, 2 down
  bit m_pend[1:10];
  int m_dir, m_cnt, m_mem;
  bit m_hold;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int c = 1; c <= 10; c++) m_pend[c] = 1'b0;
    m_dir = 0; m_cnt = 0; m_mem = 0; m_hold = 1'b0;
  endfunction

  function automatic logic [9:0] model_pend_vec();
    logic [9:0] v = '0;
    for (int c = 10; c >= 1; c--) v = {v[8:0], m_pend[c]};
    return v;
  endfunction

  function automatic void model_select(input int p);
    int floors[$];
    int cur = p + 1;
    int target = 0;
    int nd = 0;
    int bd = 99;
    int order[3];
    for (int f = 1; f <= 4; f++) begin
      bit any = 1'b0;
      for (int c = 1; c <= 10; c++) if (code_floor[c] == f && m_pend[c]) any = 1'b1;
      if (any) floors.push_back(f);
    end
    if (floors.size() == 0) begin
      m_dir = 0; m_mem = 0;
      return;
    end
    if (m_dir == 1) begin
      foreach (floors[i]) if (floors[i] >= cur && (target == 0 || floors[i] < target)) target = floors[i];
      nd = 1;
      if (target == 0) begin
        foreach (floors[i]) if (floors[i] < cur && floors[i] > target) target = floors[i];
        nd = 2;
      end
    end else if (m_dir == 2) begin
      foreach (floors[i]) if (floors[i] <= cur && floors[i] > target) target = floors[i];
      nd = 2;
      if (target == 0) begin
        foreach (floors[i]) if (floors[i] > cur && (target == 0 || floors[i] < target)) target = floors[i];
        nd = 1;
      end
    end else begin
      foreach (floors[i]) begin
        int d = (floors[i] > cur) ? floors[i] - cur : cur - floors[i];
        if (d < bd || (d == bd && floors[i] > target)) begin
          bd = d; target = floors[i];
        end
      end
      nd = (target > cur) ? 1 : (target < cur) ? 2 : 0;
    end
    m_dir = nd;
    order[0] = 0;
    order[1] = (nd == 2) ? 2 : 1;
    order[2] = (nd == 2) ? 1 : 2;
    m_mem = 0;
    for (int k = 0; k < 3; k++)
      for (int c = 1; c <= 10; c++)
        if (m_mem == 0 && code_floor[c] == target && code_kind[c] == order[k] && m_pend[c]) m_mem = c;
  endfunction

  function automatic void model_step(input logic [3:0] c, input logic [2:0] u, input logic [2:0] d,
                                     input int p, input bit door, input bit e);
    bit exit_now = e && m_hold && (m_cnt == DC - 1);
    for (int i = 0; i < 4; i++) if (c[i]) m_pend[i + 1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (u[i]) m_pend[5 + 2 * i] = 1'b1;
      if (d[i]) m_pend[6 + 2 * i] = 1'b1;
    end
    if (exit_now)
      for (int k = 1; k <= 10; k++) if (code_floor[k] == p + 1) m_pend[k] = 1'b0;
    if (e) begin
      if (m_hold) begin
        if (exit_now) begin
          m_hold = 1'b0;
          model_select(p);
        end else begin
          m_cnt++;
        end
      end else if (door) begin
        m_hold = 1'b1;
        m_cnt = 0;
      end else begin
        model_select(p);
      end
    end
  endfunction

  task automatic cyc(input logic [3:0] c, input logic [2:0] u, input logic [2:0] d,
                     input logic [1:0] p, input logic door, input logic e, input string nm);
    exp_t x;
    @(negedge clk);
    btn_cab = c; btn_up = u; btn_down = d; piso = p; puertas = door; en = e;
    model_step(c, u, d, int'(p), door, e);
    x.mem = 4'(m_mem);
    x.pend = model_pend_vec();
    x.dir = 2'(m_dir);
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic check_now(input string nm, input int mem, input int pend, input int dr);
    @(posedge clk);
    #2;
    chk({nm, ".memoria"}, int'(memoria), mem);
    chk({nm, ".pending"}, int'(pending), pend);
    chk({nm, ".dir"}, int'(dir), dr);
  endtask

  task automatic serve(input logic [1:0] p, input string nm);
    cyc(4'd0, 3'd0, 3'd0, p, 1'b1, 1'b1, {nm, "_open"});
    repeat (DC) cyc(4'd0, 3'd0, 3'd0, p, 1'b0, 1'b1, nm);
  endtask

  // Scoreboard monitor: one expected entry per driven edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".memoria"}, int'(memoria), int'(e.mem));
        chk({nm, ".pending"}, int'(pending), int'(e.pend));
        chk({nm, ".dir"}, int'(dir), int'(e.dir));
        $display("txn %-14s piso=%0d mem=%0d pend=%03h dir=%0d", nm, piso, memoria, pending, dir);
      end
    end
  end

  initial begin
    logic [3:0] rc;
    logic [2:0] ru, rd;
    logic [1:0] rp;
    model_reset();
    #12;
    chk("reset.memoria", int'(memoria), 0);
    chk("reset.pending", int'(pending), 0);
    chk("reset.dir", int'(dir), 0);
    @(negedge clk);
    rst = 1'b1;

    cyc(4'b0100, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, "cab_call");
    check_now("cab_call", 3, 10'h004, 1);

    cyc(4'd0, 3'b100, 3'b010, 2'd2, 1'b0, 1'b1, "arrive_f3");
    cyc(4'd0, 3'd0, 3'd0, 2'd2, 1'b1, 1'b1, "door_open");
    check_now("hold_entry", 3, 10'h184, 1);
    repeat (DC - 1) cyc(4'd0, 3'd0, 3'd0, 2'd2, 1'b0, 1'b1, "hold");
    check_now("hold_last", 3, 10'h184, 1);
    cyc(4'd0, 3'd0, 3'd0, 2'd2, 1'b0, 1'b1, "hold_exit");
    check_now("hold_exit", 0, 10'h000, 0);

    cyc(4'b1000, 3'd0, 3'd0, 2'd1, 1'b0, 1'b1, "scan_call4");
    cyc(4'b0001, 3'd0, 3'd0, 2'd1, 1'b0, 1'b1, "scan_call1");
    check_now("scan_up", 4, 10'h009, 1);
    cyc(4'd0, 3'd0, 3'd0, 2'd3, 1'b0, 1'b1, "arrive_f4");
    serve(2'd3, "serve_f4");
    check_now("scan_reverse", 1, 10'h001, 2);
    cyc(4'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, "arrive_f1");
    serve(2'd0, "serve_f1");
    check_now("served_f1", 0, 10'h000, 0);

    cyc(4'b0100, 3'd0, 3'd0, 2'd2, 1'b0, 1'b1, "call_here");
    check_now("call_here", 3, 10'h004, 0);
    cyc(4'd0, 3'd0, 3'd0, 2'd2, 1'b1, 1'b1, "door_open");
    repeat (DC - 1) cyc(4'd0, 3'd0, 3'd0, 2'd2, 1'b0, 1'b1, "hold");
    cyc(4'b0001, 3'd0, 3'b010, 2'd2, 1'b0, 1'b1, "collision");
    check_now("collision", 1, 10'h001, 2);

    cyc(4'd0, 3'b100, 3'd0, 2'd2, 1'b0, 1'b0, "en_low");
    check_now("en_low", 1, 10'h101, 2);
    cyc(4'd0, 3'd0, 3'd0, 2'd2, 1'b0, 1'b1, "hall_code");
    check_now("hall_code", 9, 10'h101, 2);
    serve(2'd2, "serve_f3");
    cyc(4'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, "arrive_f1");
    serve(2'd0, "serve_f1");

    cyc(4'b0101, 3'd0, 3'd0, 2'd1, 1'b0, 1'b1, "idle_tie");
    check_now("idle_tie", 3, 10'h005, 1);

    cyc(4'hF, 3'h7, 3'h7, 2'd1, 1'b0, 1'b1, "press_all");
    cyc(4'd0, 3'd0, 3'd0, 2'd1, 1'b1, 1'b1, "door_open");
    repeat (3) cyc(4'd0, 3'd0, 3'd0, 2'd1, 1'b0, 1'b1, "hold");
    @(negedge clk);
    btn_cab = '0; btn_up = '0; btn_down = '0; puertas = 1'b0; en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst.memoria", int'(memoria), 0);
    chk("async_rst.pending", int'(pending), 0);
    chk("async_rst.dir", int'(dir), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(4'd0, 3'd0, 3'd0, 2'd1, 1'b0, 1'b1, "post_reset");
    cyc(4'd0, 3'd0, 3'd0, 2'd1, 1'b0, 1'b1, "post_reset");
    check_now("post_reset", 0, 10'h000, 0);

    rp = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) rc[i] = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < 3; i++) begin
        ru[i] = ($urandom_range(0, 11) == 0);
        rd[i] = ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 3) == 0) rp = 2'($urandom_range(0, 3));
      cyc(rc, ru, rd, rp, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0), "rand");
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
